// File: rtl/clock_time_setter.sv
// clock_time_setter: debounced three-button time entry that edits a BCD hh:mm:ss buffer and loads it into the clock core
module clock_time_setter #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic [3:0] cur_h2,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_m2,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_s2,
  input  logic [3:0] cur_s1,
  output logic       edit,
  output logic [2:0] sel,
  output logic [3:0] set_h2,
  output logic [3:0] set_h1,
  output logic [3:0] set_m2,
  output logic [3:0] set_m1,
  output logic [3:0] set_s2,
  output logic [3:0] set_s1,
  output logic       load
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, CAPTURE, EDIT, COMMIT} state_t;
  state_t state, state_n;
  logic [2:0] raw, sync_a, sync_b, acc, press, sel_n;
  logic [CW-1:0] cnt [3];
  logic [3:0] dig [6], dig_n [6], cur [6];
  logic [3:0] h2c;
  logic mode_p, sel_p, inc_p;
  // digit index 0..5 = s1, s2, m1, m2, h1, h2; h1 ceiling depends on the tens-of-hours digit
  function automatic logic [3:0] lim(input logic [2:0] k, input logic [3:0] h2);
    lim = (k == 3'd0 || k == 3'd2) ? 4'd9 :
          (k == 3'd1 || k == 3'd3) ? 4'd5 :
          (k == 3'd4) ? ((h2 == 4'd2) ? 4'd3 : 4'd9) : 4'd2;
  endfunction
  assign raw = {btn_inc, btn_sel, btn_mode};
  assign cur = '{cur_s1, cur_s2, cur_m1, cur_m2, cur_h1, cur_h2};
  assign h2c = (cur_h2 > 4'd2) ? 4'd0 : cur_h2;
  assign mode_p = press[0];
  assign sel_p = press[1] & ~press[0];
  assign inc_p = press[2] & ~press[1] & ~press[0];
  assign edit = state != IDLE;
  assign load = state == COMMIT;
  assign {set_h2, set_h1, set_m2, set_m1, set_s2, set_s1} = {dig[5], dig[4], dig[3], dig[2], dig[1], dig[0]};
  // two-flop synchronizers on the raw active-low buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end
  // debounce: accept a new level after DEBOUNCE_CYCLES differing samples; pulse on accepted falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '1;
      press <= '0;
      for (int k = 0; k < 3; k++) cnt[k] <= '0;
    end else begin
      press <= '0;
      for (int k = 0; k < 3; k++) begin
        if (sync_b[k] == acc[k]) cnt[k] <= '0;
        else if (cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[k] <= '0;
          acc[k] <= sync_b[k];
          press[k] <= ~sync_b[k];
        end else cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end
  // state, selected digit and edit buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      for (int k = 0; k < 6; k++) dig[k] <= '0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      for (int k = 0; k < 6; k++) dig[k] <= dig_n[k];
    end
  end
  // next state, selection and buffer updates: capture with sanitization, wrapping increments, h1 fixup
  always_comb begin
    state_n = state;
    sel_n = sel;
    dig_n = dig;
    case (state)
      IDLE: state_n = mode_p ? CAPTURE : IDLE;
      CAPTURE: begin
        state_n = EDIT;
        sel_n = '0;
        for (int k = 0; k < 5; k++) dig_n[k] = (cur[k] > lim(3'(k), h2c)) ? 4'd0 : cur[k];
        dig_n[5] = h2c;
      end
      EDIT: begin
        state_n = mode_p ? COMMIT : EDIT;
        sel_n = sel_p ? ((sel == 3'd5) ? 3'd0 : sel + 3'd1) : sel;
        if (inc_p) begin
          for (int k = 0; k < 6; k++)
            if (3'(k) == sel) dig_n[k] = (dig[k] >= lim(sel, dig[5])) ? 4'd0 : dig[k] + 4'd1;
          if (sel == 3'd5 && dig_n[5] == 4'd2 && dig[4] > 4'd3) dig_n[4] = 4'd0;
        end
      end
      default: begin
        state_n = IDLE;
        sel_n = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_clock_time_setter.sv
// tb_clock_time_setter: directed scoreboard bench for the button-driven time setter
module tb_clock_time_setter;
  localparam logic [2:0] MODE = 3'b001, SEL = 3'b010, INC = 3'b100;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] btn = 3'b111;
  logic [3:0] cur_h2 = '0, cur_h1 = '0, cur_m2 = '0, cur_m1 = '0, cur_s2 = '0, cur_s1 = '0;
  logic edit, load;
  logic [2:0] sel;
  logic [3:0] set_h2, set_h1, set_m2, set_m1, set_s2, set_s1;
  logic [23:0] set_all;
  int total = 0, bad = 0, load_cnt = 0, l0 = 0;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t q[$];

  clock_time_setter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn[0]), .btn_sel(btn[1]), .btn_inc(btn[2]),
    .cur_h2(cur_h2), .cur_h1(cur_h1), .cur_m2(cur_m2), .cur_m1(cur_m1), .cur_s2(cur_s2), .cur_s1(cur_s1),
    .edit(edit), .sel(sel),
    .set_h2(set_h2), .set_h1(set_h1), .set_m2(set_m2), .set_m1(set_m1), .set_s2(set_s2), .set_s1(set_s1),
    .load(load)
  );

  assign set_all = {set_h2, set_h1, set_m2, set_m1, set_s2, set_s1};
  always #5 clk = ~clk;
  always @(posedge clk) if (load) load_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input string tag, input logic [31:0] v);
    q.push_back('{tag, v});
  endtask
  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic set_cur(input logic [23:0] v);
    {cur_h2, cur_h1, cur_m2, cur_m1, cur_s2, cur_s1} = v;
  endtask
  task automatic press(input logic [2:0] m, input int hold = 10);
    btn = ~m;
    cyc(hold);
    btn = 3'b111;
    cyc(12);
  endtask

  initial begin
    cyc(3);
    push("rst_edit", 0); chk(32'(edit));
    push("rst_sel", 0); chk(32'(sel));
    push("rst_set", 0); chk(32'(set_all));
    push("rst_load", 0); chk(32'(load));
    rst = 1'b0;
    cyc(2);
    set_cur(24'h123456);
    push("cap_edit", 1); push("cap_set", 24'h123456); push("cap_sel", 0);
    press(MODE);
    chk(32'(edit)); chk(32'(set_all)); chk(32'(sel));
    push("sel_1", 1); press(SEL); chk(32'(sel));
    push("s2_wrap", 24'h123406); press(INC); chk(32'(set_all));
    l0 = load_cnt;
    push("commit_load", 1); push("commit_edit", 0); push("commit_set", 24'h123406);
    press(MODE);
    chk(32'(load_cnt - l0)); chk(32'(edit)); chk(32'(set_all));
    push("idle_inc", 24'h123406); press(INC); chk(32'(set_all));
    push("idle_sel", 0); press(SEL); chk(32'(sel));
    set_cur(24'h195959);
    push("cap2_set", 24'h195959); press(MODE); chk(32'(set_all));
    push("sel_4", 4); repeat (4) press(SEL); chk(32'(sel));
    push("h1_wrap9", 24'h105959); press(INC); chk(32'(set_all));
    push("h1_to8", 24'h185959); repeat (8) press(INC); chk(32'(set_all));
    push("sel_5", 5); press(SEL); chk(32'(sel));
    push("h2_fixup", 24'h205959); press(INC); chk(32'(set_all));
    push("h2_wrap", 24'h005959); press(INC); chk(32'(set_all));
    push("sel_wrap5", 0); press(SEL); chk(32'(sel));
    push("sel_3", 3); repeat (3) press(SEL); chk(32'(sel));
    push("sel_six", 0); repeat (3) press(SEL); chk(32'(sel));
    push("glitch", 24'h005959);
    btn = ~INC; cyc(3); btn = 3'b111; cyc(12);
    chk(32'(set_all));
    push("held_once", 24'h005950); press(INC, 100); chk(32'(set_all));
    l0 = load_cnt;
    push("prio_load", 1); push("prio_set", 24'h005950); push("prio_edit", 0);
    press(MODE | INC);
    chk(32'(load_cnt - l0)); chk(32'(set_all)); chk(32'(edit));
    set_cur(24'h276A59);
    push("sanitize", 24'h200059); push("san_edit", 1);
    press(MODE);
    chk(32'(set_all)); chk(32'(edit));
    push("sel_3b", 3); repeat (3) press(SEL); chk(32'(sel));
    l0 = load_cnt;
    push("arst_edit", 0); push("arst_sel", 0); push("arst_set", 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk(32'(edit)); chk(32'(sel)); chk(32'(set_all));
    cyc(2);
    rst = 1'b0;
    cyc(20);
    push("arst_noload", 0); push("arst_idle", 0);
    chk(32'(load_cnt - l0)); chk(32'(edit));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clock_time_setter.md
# clock_time_setter

Button-driven time-entry controller for the BCD six-digit clock. It is the write path into the clock core, where the display path is the read path. It debounces three active-low push buttons and captures the live time into an edit buffer. The user then picks a digit and increments it within that digit's legal range. On exit it emits a one-cycle load pulse so the clock core adopts the edited time. Its `edit` and `sel` outputs also drive the pause and blink-select logic of the display multiplexer.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 240000 (20 ms at 12 MHz): number of consecutive stable samples required before a button level is accepted.

Ports:
- `clk`  in  1  system clock (12 MHz `Sys_Clk0` domain)
- `rst`  in  1  reset, asynchronous, active-high
- `btn_mode`  in  1  raw button, active-low; enters/exits edit mode
- `btn_sel`  in  1  raw button, active-low; advances selected digit
- `btn_inc`  in  1  raw button, active-low; increments selected digit
- `cur_h2, cur_h1, cur_m2, cur_m1, cur_s2, cur_s1`  in  4 each  live BCD time from the clock core
- `edit`  out  1  high while editing; drives clock-core pause
- `sel`  out  3  selected digit: 0=s1, 1=s2, 2=m1, 3=m2, 4=h1, 5=h2
- `set_h2, set_h1, set_m2, set_m1, set_s2, set_s1`  out  4 each  edit-buffer BCD digits
- `load`  out  1  one-cycle pulse; clock core copies `set_*` into its registers on this pulse

## Operation
- **Button input chain:** each button goes through
  - a 2-flop synchronizer (reset to 1);
  - a debouncer: a counter per button compares the synchronized level with the accepted level. The accepted level changes only after `DEBOUNCE_CYCLES` consecutive differing samples. Any agreeing sample clears the counter.
- **Press pulse:** a press pulse is 1 cycle on each 1→0 transition of the accepted level. There is no auto-repeat; a held button yields exactly one press.
- **Press priority in one cycle:** mode > sel > inc. Lower-priority presses in that same cycle are discarded.
- **FSM states:**
  - IDLE: `edit`=0. A mode press goes to CAPTURE.
  - CAPTURE (1 cycle): copy `cur_*` into the buffer, set `sel`=0, `edit`=1, then go to EDIT.
  - EDIT: `edit`=1.
    - sel press: `sel` = (`sel`==5) ? 0 : `sel`+1.
    - inc press: increment the selected digit, wrapping as listed below.
    - mode press: go to COMMIT.
  - COMMIT (1 cycle): `load`=1, `edit` still 1. Go to IDLE the next cycle with `sel`=0.
- **Digit ranges (wrap to 0 past max):**
  - s1, m1: 0–9.
  - s2, m2: 0–5.
  - h2: 0–2.
  - h1: 0–9 when h2<2, 0–3 when h2==2.
- **Cross-digit fixup:** if an h2 increment makes h2==2 while h1>3, h1 is forced to 0 in the same cycle.
- **Capture sanitization:** any captured digit above its max is stored as 0, including h1>3 when the captured h2==2.
- **Buffer hold:** `set_*` hold their values in IDLE and are not tracked from `cur_*` outside CAPTURE.

## Timing
- **Reset values (asynchronous, immediate):**
  - state IDLE; `edit`=0, `sel`=0, `load`=0.
  - all `set_*`=0.
  - synchronizers and accepted levels = 1; debounce counters = 0.
- **Press latency:** a raw edge stable from cycle 0 produces its press pulse at cycle 2+`DEBOUNCE_CYCLES`, ±1 cycle.
- **Press effects:**
  - mode press in IDLE: `edit`=1 and the buffer is valid one cycle after the press pulse (the CAPTURE cycle registers).
  - sel/inc press in EDIT: updated `sel`/digit is visible the cycle after the press pulse.
  - mode press in EDIT: `load` is high exactly one cycle, starting the cycle after the press pulse. `set_*` are stable during and after `load`.
- **Presses outside EDIT:** sel/inc presses in IDLE, CAPTURE or COMMIT are ignored.
- **Glitches:** a raw pulse shorter than `DEBOUNCE_CYCLES` samples produces no press.
- **Reset mid-edit:** return to IDLE with no `load` pulse. The clock core therefore resumes unpaused with its own time.
- **Release edges:** 0→1 accepted-level transitions generate no action.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4.
- **Reset:** assert `rst` mid-EDIT with `sel`=3 → `edit`=0, `sel`=0, `set_*`=0 immediately; no `load` pulse after release.
- **Capture and sanitization:** `cur`=1,2,3,4,5,6 (h2..s1), mode press → `edit`=1, `set`=1,2,3,4,5,6, `sel`=0. Repeat with `cur_h2`=2, `cur_h1`=7 → `set_h1`=0.
- **Increment wrap:**
  - `sel`=1 from s2=5, inc → s2=0.
  - `sel`=4 with h2=1, h1=9, inc → h1=0.
  - `sel`=5 from h2=1 with h1=8, inc → h2=2, h1=0.
  - inc on h2=2 → h2=0.
- **Select wrap and commit:** six sel presses from `sel`=0 → `sel`=0. Mode press → exactly one `load`=1 cycle, then `edit`=0.
- **Debounce and priority:**
  - btn_inc low for 3 cycles → no change.
  - Held low 100 cycles → exactly one increment.
  - mode and inc pressed in the same cycle in EDIT → commit only; digit unchanged.
